// File: rtl/spram_responder.sv
// SB_SPRAM256KA front end: posted writes, in-order read returns through a
// 4-deep response FIFO, and automatic standby after a quiet period.
module spram_responder #(
    parameter int unsigned IDLE_CYCLES = 64,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [13:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    input  logic        rsp_ready,
    output logic [13:0] ram_addr,
    output logic [15:0] ram_datain,
    output logic [3:0]  ram_maskwren,
    output logic        ram_wren,
    output logic        ram_cs,
    output logic        ram_standby,
    input  logic [15:0] ram_dataout
);
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned IW    = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned WW    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STANDBY = 2'd1,
        ST_WAKE    = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idle_cnt, idle_cnt_n;
    logic [WW-1:0]   wake_cnt, wake_cnt_n;

    logic            rd_s1;
    logic            rd_s2;
    logic [DW-1:0]   fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_ptr_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic [CW-1:0]   rif;
    logic [CW-1:0]   rif_n;

    logic            accept;
    logic            rd_accept;
    logic            push;
    logic            pop;
    logic            quiet;
    logic            ready_n;
    logic [DW-1:0]   head_n;

    // Handshakes and occupancy bookkeeping; rd_s1/rd_s2 track the two-cycle RAM read pipe
    always_comb begin
        accept    = req_valid && req_ready;
        rd_accept = accept && !req_we;
        push      = rd_s2;
        pop       = rsp_valid && rsp_ready;
        rif       = CW'(rd_s1) + CW'(rd_s2);
        rif_n     = CW'(rd_accept) + CW'(rd_s1);
        count_n   = count + CW'(push) - CW'(pop);
        rd_ptr_n  = rd_ptr + PW'(pop);
        quiet     = !accept && (rif == '0) && (count == '0);
    end

    // Power-state next-state logic
    always_comb begin
        state_n    = state;
        idle_cnt_n = '0;
        wake_cnt_n = '0;
        unique case (state)
            ST_RUN: begin
                if (quiet) begin
                    if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
                        state_n = ST_STANDBY;
                    end else begin
                        idle_cnt_n = idle_cnt + IW'(1);
                    end
                end
            end
            ST_STANDBY: begin
                if (req_valid) begin
                    state_n = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (wake_cnt == WW'(WAKE_CYCLES - 1)) begin
                    state_n = ST_RUN;
                end else begin
                    wake_cnt_n = wake_cnt + WW'(1);
                end
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    // Registered ready/head are computed from next-cycle occupancy so they match the live view
    always_comb begin
        ready_n = (state_n == ST_RUN) && (CW'(count_n + rif_n) < CW'(DEPTH));
        head_n  = (push && (wr_ptr == rd_ptr_n)) ? ram_dataout : fifo_mem[rd_ptr_n];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            state    <= state_n;
            idle_cnt <= idle_cnt_n;
            wake_cnt <= wake_cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ram_dataout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rd_s1        <= 1'b0;
            rd_s2        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            ram_addr     <= '0;
            ram_datain   <= '0;
            ram_maskwren <= '0;
            ram_wren     <= 1'b0;
            ram_cs       <= 1'b0;
            ram_standby  <= 1'b0;
        end else begin
            req_ready    <= ready_n;
            rsp_valid    <= (count_n != '0);
            rsp_rdata    <= (count_n != '0) ? head_n : '0;
            rd_s1        <= rd_accept;
            rd_s2        <= rd_s1;
            wr_ptr       <= wr_ptr + PW'(push);
            rd_ptr       <= rd_ptr_n;
            count        <= count_n;
            ram_cs       <= accept;
            ram_wren     <= accept && req_we;
            ram_maskwren <= (accept && req_we) ? req_mask : '0;
            if (accept) begin
                ram_addr <= req_addr;
            end
            if (accept && req_we) begin
                ram_datain <= req_wdata;
            end
            ram_standby  <= (state_n == ST_STANDBY);
        end
    end

endmodule

// File: tb/tb_spram_responder.sv
// Bench for spram_responder: directed vector table, multi-cycle corner sequences
// and random traffic against a behavioural SPRAM and an in-order read scoreboard.
`timescale 1ns/1ps
module tb_spram_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic [3:0]  req_mask;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_ready;
    logic [13:0] ram_addr;
    logic [15:0] ram_datain;
    logic [3:0]  ram_maskwren;
    logic        ram_wren;
    logic        ram_cs;
    logic        ram_standby;
    logic [15:0] ram_dataout;

    spram_responder #(
        .IDLE_CYCLES(64),
        .WAKE_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_mask     (req_mask),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_ready    (rsp_ready),
        .ram_addr     (ram_addr),
        .ram_datain   (ram_datain),
        .ram_maskwren (ram_maskwren),
        .ram_wren     (ram_wren),
        .ram_cs       (ram_cs),
        .ram_standby  (ram_standby),
        .ram_dataout  (ram_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SB_SPRAM256KA: synchronous, nibble-masked writes, registered read data
    logic [15:0] sram [0:16383];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wren) begin
                for (int i = 0; i < 4; i++) begin
                    if (ram_maskwren[i]) sram[ram_addr][4*i +: 4] <= ram_datain[4*i +: 4];
                end
            end else begin
                ram_dataout <= sram[ram_addr];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int rsp_seen = 0;
    int reads_total = 0;

    typedef struct {
        logic [15:0] data;
        int          t;
    } exp_t;
    exp_t exp_q[$];
    logic [15:0] ref_mem [0:16383];

    typedef struct {
        bit          we;
        logic [13:0] addr;
        logic [15:0] data;
        logic [3:0]  mask;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [17];
    logic [13:0] rd_list [6];

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: memory with nibble masks; reads queue the value seen at acceptance time
    task automatic model_accept(input bit we, input logic [13:0] a, input logic [15:0] d,
                                input logic [3:0] m);
        exp_t e;
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) ref_mem[a][4*i +: 4] = d[4*i +: 4];
            end
        end else begin
            e.data = ref_mem[a];
            e.t    = cyc;
            exp_q.push_back(e);
            reads_total++;
        end
    endtask

    // One clock: drive, check outputs against the model, advance, update the model
    task automatic step(input bit v, input bit we, input logic [13:0] a, input logic [15:0] d,
                        input logic [3:0] m, input bit rr, input bit chk_rdy, output bit acc);
        bit pop;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_mask  = m;
        rsp_ready = rr;
        acc = v && req_ready;
        pop = rsp_valid && rr;
        if (chk_rdy) chk_bit("req_ready_credit", req_ready, exp_q.size() < 4);
        chk_bit("rsp_valid", rsp_valid, (exp_q.size() > 0) && (exp_q[0].t + 2 <= cyc));
        if (pop && exp_q.size() > 0) chk_val("rsp_rdata", rsp_rdata, exp_q[0].data);
        @(posedge clk);
        #1;
        if (pop && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            rsp_seen++;
        end
        if (acc) model_accept(we, a, d, m);
    endtask

    task automatic drain(input int budget);
        bit acc;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step(1'b0, 1'b0, 14'd0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
            n++;
        end
        chk_val("drain_left", 16'(exp_q.size()), 16'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_bit({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk_bit({tag, "_ram_cs"}, ram_cs, 1'b0);
        chk_bit({tag, "_ram_wren"}, ram_wren, 1'b0);
        chk_val({tag, "_ram_maskwren"}, 16'(ram_maskwren), 16'h0);
        chk_bit({tag, "_ram_standby"}, ram_standby, 1'b0);
        chk_val({tag, "_ram_addr"}, 16'(ram_addr), 16'h0);
        chk_val({tag, "_ram_datain"}, ram_datain, 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int issued;
        int idx;
        int seen0;
        int n;
        bit rv, rwe, rrr;
        logic [13:0] ra;
        logic [15:0] rdat;
        logic [3:0]  rm;

        tbl[0]  = '{1'b1, 14'd0,     16'h0001, 4'hF, 16'h0000};
        tbl[1]  = '{1'b1, 14'd1,     16'h0002, 4'hF, 16'h0000};
        tbl[2]  = '{1'b1, 14'd2,     16'h0004, 4'hF, 16'h0000};
        tbl[3]  = '{1'b1, 14'd3,     16'h0007, 4'hF, 16'h0000};
        tbl[4]  = '{1'b0, 14'd0,     16'h0000, 4'h0, 16'h0001};
        tbl[5]  = '{1'b0, 14'd1,     16'h0000, 4'h0, 16'h0002};
        tbl[6]  = '{1'b0, 14'd2,     16'h0000, 4'h0, 16'h0004};
        tbl[7]  = '{1'b0, 14'd3,     16'h0000, 4'h0, 16'h0007};
        tbl[8]  = '{1'b1, 14'd5,     16'hFFFF, 4'hF, 16'h0000};
        tbl[9]  = '{1'b1, 14'd5,     16'h1234, 4'h3, 16'h0000};
        tbl[10] = '{1'b0, 14'd5,     16'h0000, 4'h0, 16'hFF34};
        tbl[11] = '{1'b1, 14'd5,     16'h0000, 4'h0, 16'h0000};
        tbl[12] = '{1'b0, 14'd5,     16'h0000, 4'h0, 16'hFF34};
        tbl[13] = '{1'b1, 14'h3FFF,  16'h5A5A, 4'hF, 16'h0000};
        tbl[14] = '{1'b0, 14'h3FFF,  16'h0000, 4'h0, 16'h5A5A};
        tbl[15] = '{1'b1, 14'h3FFF,  16'hC3C3, 4'hA, 16'h0000};
        tbl[16] = '{1'b0, 14'h3FFF,  16'h0000, 4'h0, 16'hCACA};
        rd_list[0] = 14'd0;
        rd_list[1] = 14'd1;
        rd_list[2] = 14'd2;
        rd_list[3] = 14'd3;
        rd_list[4] = 14'd5;
        rd_list[5] = 14'h3FFF;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_mask  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        chk_bit("ready_after_reset", req_ready, 1'b1);

        // Directed vectors, one transaction at a time
        for (int i = 0; i < 17; i++) begin
            step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].mask, 1'b1, 1'b1, acc);
            chk_bit("tbl_accept", acc, 1'b1);
            chk_bit("tbl_ram_cs", ram_cs, 1'b1);
            chk_bit("tbl_ram_wren", ram_wren, tbl[i].we);
            chk_val("tbl_ram_addr", 16'(ram_addr), 16'(tbl[i].addr));
            chk_val("tbl_ram_maskwren", 16'(ram_maskwren), tbl[i].we ? 16'(tbl[i].mask) : 16'h0);
            if (tbl[i].we) chk_val("tbl_ram_datain", ram_datain, tbl[i].data);
            step(1'b0, 1'b0, 14'd0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
            chk_bit("tbl_cs_release", ram_cs, 1'b0);
            chk_bit("tbl_wren_release", ram_wren, 1'b0);
            chk_val("tbl_mask_release", 16'(ram_maskwren), 16'h0);
            if (!tbl[i].we) begin
                step(1'b0, 1'b0, 14'd0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
                chk_bit("tbl_rsp_valid", rsp_valid, 1'b1);
                chk_val("tbl_rsp_rdata", rsp_rdata, tbl[i].exp);
            end
        end
        drain(10);

        // Six back-to-back reads against a stalled response path
        issued = 0;
        seen0  = rsp_seen;
        for (int c = 0; c < 10; c++) begin
            idx = (issued < 6) ? issued : 5;
            step(issued < 6, 1'b0, rd_list[idx], 16'd0, 4'd0, 1'b0, 1'b1, acc);
            if (acc) issued++;
        end
        chk_val("burst_accepted_stalled", 16'(issued), 16'd4);
        chk_bit("burst_ready_low", req_ready, 1'b0);
        chk_bit("burst_rsp_valid", rsp_valid, 1'b1);
        for (int c = 0; c < 40 && !(issued == 6 && exp_q.size() == 0); c++) begin
            idx = (issued < 6) ? issued : 5;
            step(issued < 6, 1'b0, rd_list[idx], 16'd0, 4'd0, 1'b1, 1'b1, acc);
            if (acc) issued++;
        end
        chk_val("burst_accepted_total", 16'(issued), 16'd6);
        chk_val("burst_responses", 16'(rsp_seen - seen0), 16'd6);

        // Idle into standby, then wake on a read
        for (int j = 1; j <= 63; j++) step(1'b0, 1'b0, 14'd0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
        chk_bit("standby_not_early", ram_standby, 1'b0);
        chk_bit("ready_before_standby", req_ready, 1'b1);
        step(1'b0, 1'b0, 14'd0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
        chk_bit("standby_entered", ram_standby, 1'b1);
        chk_bit("standby_ready_low", req_ready, 1'b0);
        repeat (5) step(1'b0, 1'b0, 14'd0, 16'd0, 4'd0, 1'b1, 1'b0, acc);
        chk_bit("standby_held", ram_standby, 1'b1);
        seen0 = rsp_seen;
        step(1'b1, 1'b0, 14'd2, 16'd0, 4'd0, 1'b1, 1'b0, acc);
        chk_bit("wake1_no_accept", acc, 1'b0);
        chk_bit("wake_standby_low", ram_standby, 1'b0);
        chk_bit("wake1_ready_low", req_ready, 1'b0);
        step(1'b1, 1'b0, 14'd2, 16'd0, 4'd0, 1'b1, 1'b0, acc);
        chk_bit("wake2_no_accept", acc, 1'b0);
        chk_bit("wake2_ready_low", req_ready, 1'b0);
        step(1'b1, 1'b0, 14'd2, 16'd0, 4'd0, 1'b1, 1'b0, acc);
        chk_bit("wake3_no_accept", acc, 1'b0);
        chk_bit("wake_ready_high", req_ready, 1'b1);
        step(1'b1, 1'b0, 14'd2, 16'd0, 4'd0, 1'b1, 1'b1, acc);
        chk_bit("wake_accept", acc, 1'b1);
        drain(10);
        chk_val("wake_responses", 16'(rsp_seen - seen0), 16'd1);

        // Reset while two reads are in flight
        step(1'b1, 1'b0, 14'd0, 16'd0, 4'd0, 1'b0, 1'b1, acc);
        chk_bit("rst_rd1_accept", acc, 1'b1);
        step(1'b1, 1'b0, 14'd1, 16'd0, 4'd0, 1'b0, 1'b1, acc);
        chk_bit("rst_rd2_accept", acc, 1'b1);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) step(1'b0, 1'b0, 14'd0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
        chk_bit("post_reset_rsp_valid", rsp_valid, 1'b0);

        // Random traffic over a pre-written window
        for (int i = 0; i < 16; i++) begin
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 20) begin
                step(1'b1, 1'b1, 14'(14'h100 + i), 16'($urandom), 4'hF, 1'b1, 1'b1, acc);
                n++;
            end
            chk_bit("seed_write_accept", acc, 1'b1);
        end
        seen0 = rsp_seen;
        n     = reads_total;
        for (int c = 0; c < 2000; c++) begin
            rv   = ($urandom_range(0, 3) != 0);
            rwe  = ($urandom_range(0, 1) != 0);
            ra   = 14'(14'h100 + $urandom_range(0, 15));
            rdat = 16'($urandom);
            rm   = 4'($urandom);
            rrr  = ($urandom_range(0, 2) != 0);
            step(rv, rwe, ra, rdat, rm, rrr, 1'b1, acc);
        end
        drain(40);
        chk_val("rand_response_count", 16'(rsp_seen - seen0), 16'(reads_total - n));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
